// File: rtl/fetch_stage.sv
// fetch_stage: single-cycle instruction fetch with internal instruction memory.
// The PC is a byte address. Instruction memory is word-indexed by
// PC[log2(IMEM_DEPTH)+1:2] and wraps modulo IMEM_DEPTH.
// A branch parks the stage in BR_WAIT, which emits bubbles until writeback
// redirects the PC.
// Optional feature: define FETCH_PERF_CNT_EN to add two saturating counters,
// O_BrStallCnt and O_DepStallCnt.

`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef IR_WIDTH
`define IR_WIDTH 32
`endif

module fetch_stage #(
  parameter int unsigned             IMEM_DEPTH = 1024,
  parameter logic [`IR_WIDTH-1:0]    BUBBLE_IR  = 32'hFF000000,
  parameter logic [`PC_WIDTH-1:0]    RESET_PC   = '0
) (
  input  logic                  I_CLOCK,
  input  logic                  I_RESET_N,
  input  logic                  I_DepStallSignal,
  input  logic                  I_BranchStallSignal,
  input  logic                  I_GPUStallSignal,
  input  logic                  I_WriteBackPCEn,
  input  logic [`PC_WIDTH-1:0]  I_WriteBackPC,
  input  logic                  I_IMemWEn,
  input  logic [`PC_WIDTH-1:0]  I_IMemWAddr,
  input  logic [`IR_WIDTH-1:0]  I_IMemWData,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]           O_BrStallCnt,
  output logic [31:0]           O_DepStallCnt,
`endif
  output logic [`PC_WIDTH-1:0]  O_PC,
  output logic [`IR_WIDTH-1:0]  O_IR,
  output logic                  O_FE_Valid
);

  localparam int unsigned AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

  typedef enum logic {
    FETCH   = 1'b0,
    BR_WAIT = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [`PC_WIDTH-1:0]   pc_q, pc_d;
  logic [`PC_WIDTH-1:0]   o_pc_q, o_pc_d;
  logic [`IR_WIDTH-1:0]   o_ir_q, o_ir_d;
  logic                   o_valid_q, o_valid_d;

  logic [`IR_WIDTH-1:0]   imem [IMEM_DEPTH];
  logic [AW-1:0]          rd_idx;
  logic [AW-1:0]          wr_idx;
  logic [`IR_WIDTH-1:0]   imem_rdata;
  logic [`PC_WIDTH-1:0]   pc_plus4;

  // The low byte-offset bits and the bits above the memory index are deliberately ignored.
  logic                   unused_addr_bits;

  assign rd_idx           = pc_q[AW+1:2];
  assign wr_idx           = I_IMemWAddr[AW+1:2];
  assign imem_rdata       = imem[rd_idx];
  assign pc_plus4         = pc_q + `PC_WIDTH'(4);
  assign unused_addr_bits = ^{pc_q, I_IMemWAddr};

  // Instruction memory write port. There is no reset, so contents survive reset.
  // A fetch on the same edge as a write to that address sees the old word.
  always_ff @(posedge I_CLOCK) begin
    if (I_IMemWEn) begin
      imem[wr_idx] <= I_IMemWData;
    end
  end

  // Next-state logic, evaluated in priority order:
  // redirect > GPU stall > dep stall > branch > fetch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    o_pc_d    = o_pc_q;
    o_ir_d    = o_ir_q;
    o_valid_d = o_valid_q;
    if (I_WriteBackPCEn) begin
      pc_d      = I_WriteBackPC;
      state_d   = FETCH;
      o_ir_d    = BUBBLE_IR;
      o_valid_d = 1'b0;
    end else if (I_GPUStallSignal || I_DepStallSignal) begin
      // Hold everything.
    end else begin
      unique case (state_q)
        FETCH: begin
          if (I_BranchStallSignal) begin
            state_d   = BR_WAIT;
            o_ir_d    = BUBBLE_IR;
            o_valid_d = 1'b0;
          end else begin
            o_ir_d    = imem_rdata;
            o_pc_d    = pc_plus4;
            o_valid_d = 1'b1;
            pc_d      = pc_plus4;
          end
        end
        BR_WAIT: begin
          o_ir_d    = BUBBLE_IR;
          o_valid_d = 1'b0;
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  // Pipeline state register with asynchronous active-low reset.
  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      o_pc_q    <= '0;
      o_ir_q    <= BUBBLE_IR;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      o_pc_q    <= o_pc_d;
      o_ir_q    <= o_ir_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign O_PC       = o_pc_q;
  assign O_IR       = o_ir_q;
  assign O_FE_Valid = o_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] dep_cnt_q, dep_cnt_d;
  logic        br_bubble;
  logic        dep_hold;

  // Counter increments. A redirect that arrives in BR_WAIT still counts,
  // because the bubble it emits on that edge is the tail of the branch wait.
  always_comb begin
    br_bubble = ((state_q == BR_WAIT) &&
                 (I_WriteBackPCEn || (!I_GPUStallSignal && !I_DepStallSignal))) ||
                ((state_q == FETCH) && !I_WriteBackPCEn && !I_GPUStallSignal &&
                 !I_DepStallSignal && I_BranchStallSignal);
    dep_hold  = !I_WriteBackPCEn && !I_GPUStallSignal && I_DepStallSignal;
    br_cnt_d  = br_cnt_q;
    dep_cnt_d = dep_cnt_q;
    if (br_bubble && (br_cnt_q != '1)) begin
      br_cnt_d = br_cnt_q + 32'd1;
    end
    if (dep_hold && (dep_cnt_q != '1)) begin
      dep_cnt_d = dep_cnt_q + 32'd1;
    end
  end

  // Saturating performance counter registers.
  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      br_cnt_q  <= '0;
      dep_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      dep_cnt_q <= dep_cnt_d;
    end
  end

  assign O_BrStallCnt  = br_cnt_q;
  assign O_DepStallCnt = dep_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage using directed vectors.

`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef IR_WIDTH
`define IR_WIDTH 32
`endif

module tb_fetch_stage;

  localparam logic [31:0] BUB = 32'hFF000000;

  typedef struct {
    logic        ev;
    logic [31:0] eir;
    logic [31:0] epc;
    logic        cpc;
    string       nm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dep, br, gpu, wben;
  logic [31:0] wbpc;
  logic        we;
  logic [31:0] waddr, wdata;
  logic [31:0] o_pc, o_ir;
  logic        o_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] br_cnt, dep_cnt;
`endif

  logic        nx_we = 1'b0;
  logic [31:0] nx_wa = '0;
  logic [31:0] nx_wd = '0;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  fetch_stage #(
    .IMEM_DEPTH(1024),
    .BUBBLE_IR (32'hFF000000),
    .RESET_PC  (32'h0)
  ) dut (
    .I_CLOCK            (clk),
    .I_RESET_N          (rst_n),
    .I_DepStallSignal   (dep),
    .I_BranchStallSignal(br),
    .I_GPUStallSignal   (gpu),
    .I_WriteBackPCEn    (wben),
    .I_WriteBackPC      (wbpc),
    .I_IMemWEn          (we),
    .I_IMemWAddr        (waddr),
    .I_IMemWData        (wdata),
`ifdef FETCH_PERF_CNT_EN
    .O_BrStallCnt       (br_cnt),
    .O_DepStallCnt      (dep_cnt),
`endif
    .O_PC               (o_pc),
    .O_IR               (o_ir),
    .O_FE_Valid         (o_valid)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a falling edge: drive inputs for the next rising edge, queue the
  // expected result, then advance to the next falling edge.
  task automatic step(input logic s_dep, input logic s_br, input logic s_gpu,
                      input logic s_wb, input logic [31:0] s_wbpc,
                      input logic ev, input logic [31:0] eir, input logic [31:0] epc,
                      input logic cpc, input string nm);
    exp_t e;
    dep = s_dep; br = s_br; gpu = s_gpu; wben = s_wb; wbpc = s_wbpc;
    we = nx_we; waddr = nx_wa; wdata = nx_wd;
    nx_we = 1'b0;
    e.ev = ev; e.eir = eir; e.epc = epc; e.cpc = cpc; e.nm = nm;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    #1;
    chk({nm, "_rst_pc"},    o_pc, 32'h0);
    chk({nm, "_rst_ir"},    o_ir, BUB);
    chk({nm, "_rst_valid"}, {31'b0, o_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: one rising edge consumes one queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.nm, "_valid"}, {31'b0, o_valid}, {31'b0, e.ev});
        chk({e.nm, "_ir"}, o_ir, e.eir);
        if (e.cpc) chk({e.nm, "_pc"}, o_pc, e.epc);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    dep = 0; br = 0; gpu = 0; wben = 0; wbpc = '0;
    we = 0; waddr = '0; wdata = '0;
    @(negedge clk);
    chk("init_pc", o_pc, 32'h0);
    chk("init_ir", o_ir, BUB);
    chk("init_valid", {31'b0, o_valid}, 32'h0);
    load(32'h000, 32'h100); load(32'h004, 32'h200); load(32'h008, 32'h300);
    load(32'h00C, 32'h400); load(32'h010, 32'h500); load(32'h020, 32'h800);
    load(32'h024, 32'h900); load(32'h040, 32'h1600); load(32'h044, 32'h1700);
    load(32'hFFC, 32'hABCD);
    rst_n = 1'b1;

    // Straight-line fetch right after reset release.
    step(0,0,0,0,0, 1, 32'h100, 32'h4, 1, "seq0");
    step(0,0,0,0,0, 1, 32'h200, 32'h8, 1, "seq1");
    step(0,0,0,0,0, 1, 32'h300, 32'hC, 1, "seq2");

    // Dependency stall holds the output for three edges.
    do_reset("b");
    step(0,0,0,0,0, 1, 32'h100, 32'h4, 1, "dep_pre");
    for (int i = 0; i < 3; i++) step(1,0,0,0,0, 1, 32'h100, 32'h4, 1, "dep_hold");
    step(0,0,0,0,0, 1, 32'h200, 32'h8, 1, "dep_post");
`ifdef FETCH_PERF_CNT_EN
    chk("dep_cnt", dep_cnt, 32'd3);
    chk("br_cnt_b", br_cnt, 32'd0);
`endif

    // Branch wait, then a redirect to 0x40.
    do_reset("c");
    step(0,0,0,0,0,          1, 32'h100, 32'h4, 1, "br_pre");
    step(0,1,0,0,0,          0, BUB, 0, 0, "br_bub1");
    step(0,1,0,0,0,          0, BUB, 0, 0, "br_bub2");
    step(0,0,0,1,32'h40,     0, BUB, 0, 0, "br_bub3");
    step(0,0,0,0,0,          1, 32'h1600, 32'h44, 1, "br_tgt");
    step(0,0,0,0,0,          1, 32'h1700, 32'h48, 1, "br_tgt1");
`ifdef FETCH_PERF_CNT_EN
    chk("br_cnt", br_cnt, 32'd3);
    chk("dep_cnt_c", dep_cnt, 32'd0);
`endif

    // A redirect overrides GPU and dep stalls. A GPU stall then holds.
    step(1,0,1,1,32'h20,     0, BUB, 0, 0, "wb_ovr");
    step(0,0,0,0,0,          1, 32'h800, 32'h24, 1, "wb_tgt");
    step(0,0,1,0,0,          1, 32'h800, 32'h24, 1, "gpu_hold");
    step(1,1,1,0,0,          1, 32'h800, 32'h24, 1, "gpu_dep_hold");
    step(0,0,0,0,0,          1, 32'h900, 32'h28, 1, "gpu_post");

    // PC+4 wraps at 2^32, and memory addressing wraps modulo the depth.
    step(0,0,0,1,32'hFFFFFFFC, 0, BUB, 0, 0, "wrap_wb");
    step(0,0,0,0,0,          1, 32'hABCD, 32'h0, 1, "wrap_top");
    step(0,0,0,0,0,          1, 32'h100, 32'h4, 1, "wrap_zero");
    step(0,0,0,1,32'h1008,   0, BUB, 0, 0, "alias_wb");
    step(0,0,0,0,0,          1, 32'h300, 32'h100C, 1, "alias_rd");

    // A write and a read of the same word on one edge returns the old data.
    step(0,0,0,1,32'h10,     0, BUB, 0, 0, "raw_wb");
    nx_we = 1'b1; nx_wa = 32'h10; nx_wd = 32'hDEAD;
    step(0,0,0,0,0,          1, 32'h500, 32'h14, 1, "raw_old");
    step(0,0,0,1,32'h10,     0, BUB, 0, 0, "raw_wb2");
    step(0,0,0,0,0,          1, 32'hDEAD, 32'h14, 1, "raw_new");

    // Drop reset mid-cycle while in BR_WAIT.
    step(0,1,0,0,0,          0, BUB, 0, 0, "mid_br");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pc", o_pc, 32'h0);
    chk("mid_rst_ir", o_ir, BUB);
    chk("mid_rst_valid", {31'b0, o_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0,0,0,0,0,          1, 32'h100, 32'h4, 1, "mid_post0");
    step(0,0,0,0,0,          1, 32'h200, 32'h8, 1, "mid_post1");

    for (int i = 0; i < 10; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
      #2;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d left expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter IMEM_DEPTH, default 1024: number of 32-bit instruction words in the internal instruction memory.
REQ-002 Parameter BUBBLE_IR, default 32'hFF000000: instruction word driven on O_IR for a bubble.
REQ-003 Parameter RESET_PC, default 0: byte address fetched first after reset.
REQ-004 I_CLOCK  in  1: single clock; all state updates on rising edge.
REQ-005 I_RESET_N  in  1: asynchronous, active-low reset.
REQ-006 I_DepStallSignal  in  1: decode dependency stall; hold the current fetch output.
REQ-007 I_BranchStallSignal  in  1: decode reports that it holds a branch, JMP, JSR or JSRR.
REQ-008 I_GPUStallSignal  in  1: downstream stall; freeze the stage.
REQ-009 I_WriteBackPCEn  in  1: redirect strobe from writeback.
REQ-010 I_WriteBackPC  in  `PC_WIDTH: redirect target byte address.
REQ-011 I_IMemWEn, I_IMemWAddr[`PC_WIDTH-1:0], I_IMemWData[`IR_WIDTH-1:0]  in: instruction memory load port.
REQ-012 O_PC  out  `PC_WIDTH: PC of the instruction on O_IR plus 4.
REQ-013 O_IR  out  `IR_WIDTH: fetched instruction or BUBBLE_IR.
REQ-014 O_FE_Valid  out  1: O_IR is a real instruction.

Function
REQ-015 Instruction memory SHALL be word-addressed by PC[log2(IMEM_DEPTH)+1:2]; PC bits [1:0] SHALL be ignored; addresses beyond depth SHALL wrap modulo IMEM_DEPTH.
REQ-016 Internal state machine SHALL have states FETCH and BR_WAIT.
REQ-017 Per-edge priority SHALL be: reset > I_WriteBackPCEn > I_GPUStallSignal > I_DepStallSignal > I_BranchStallSignal > normal fetch.
REQ-018 Normal fetch (FETCH, no stalls): O_IR <= IMEM[PC], O_PC <= PC+4, O_FE_Valid <= 1, PC <= PC+4; latency one cycle.
REQ-019 GPU or dep stall SHALL hold PC, O_PC, O_IR, O_FE_Valid and state unchanged.
REQ-020 I_BranchStallSignal in FETCH SHALL move to BR_WAIT, leave PC unchanged, and drive O_IR <= BUBBLE_IR, O_FE_Valid <= 0.
REQ-021 In BR_WAIT without I_WriteBackPCEn, bubbles SHALL continue and PC SHALL stay frozen; I_BranchStallSignal SHALL be ignored.
REQ-022 I_WriteBackPCEn in any state SHALL set PC <= I_WriteBackPC, state <= FETCH, O_IR <= BUBBLE_IR, O_FE_Valid <= 0; the target is fetched on the following edge.
REQ-023 I_WriteBackPCEn simultaneous with any stall SHALL take the redirect and override the stalls.
REQ-024 PC+4 SHALL wrap modulo 2^`PC_WIDTH with no flag.
REQ-025 Memory write SHALL be synchronous; a same-edge fetch of the written address SHALL return the old data.

Reset
REQ-026 While I_RESET_N=0: PC=RESET_PC, state=FETCH, O_PC=0, O_IR=BUBBLE_IR, O_FE_Valid=0, independent of the clock.
REQ-027 Reset asserted in BR_WAIT or during a stall SHALL abort it; the first fetch from RESET_PC SHALL occur on the first rising edge after release.
REQ-028 Instruction memory contents SHALL NOT be cleared by reset.

Configuration
REQ-029 With FETCH_PERF_CNT_EN defined: add outputs O_BrStallCnt[31:0] and O_DepStallCnt[31:0], both reset to 0, saturating at 32'hFFFFFFFF.
REQ-030 O_BrStallCnt SHALL increment on each edge that produces a bubble because of BR_WAIT or branch entry; O_DepStallCnt SHALL increment on each edge held by I_DepStallSignal.
REQ-031 Without FETCH_PERF_CNT_EN: these ports and counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Load 0x100,0x200,0x300 at addresses 0,4,8, release reset, no stalls -> O_IR 0x100,0x200,0x300 on consecutive cycles with O_PC 4,8,12 and O_FE_Valid=1.
REQ-033 Assert dep stall for 3 cycles after the first fetch -> O_IR=0x100 and O_PC=4 held for 3 cycles, then 0x200 follows.
REQ-034 Branch stall for 1 cycle, I_WriteBackPCEn with target 0x40 two cycles later -> 3 bubbles with O_FE_Valid=0, then IMEM[16] with O_PC=0x44.
REQ-035 I_WriteBackPCEn with target 0x20 together with GPU and dep stall -> redirect taken, next valid O_IR=IMEM[8].
REQ-036 Drop I_RESET_N mid-cycle while in BR_WAIT -> outputs at reset values immediately; after release, fetch restarts at RESET_PC.
REQ-037 With FETCH_PERF_CNT_EN: scenario REQ-034 -> O_BrStallCnt=3; scenario REQ-033 -> O_DepStallCnt=3.
